// File: rtl/fx68_bus_ctrl.sv
// fx68_bus_ctrl: 68000 bus-cycle controller for fx68k (phi enables,
// region decode, wait states, DTACK/BERR/VPA, IPL). Macro: FX68_BUS_IRQ_EN.
// Ports: clk, reset_n | phi1, phi2 | as_n, uds_n, lds_n, rw, fc, addr,
// slave_ready, irq_in | sel, dtack_n, vpa_n, berr_n, ipl_n.
module fx68_bus_ctrl #(
  parameter int                     N_REGIONS    = 4,
  parameter logic [8*N_REGIONS-1:0] REGION_BASE  = 32'hE0C08000,
  parameter logic [8*N_REGIONS-1:0] REGION_MASK  = 32'hE0E0E080,
  parameter logic [4*N_REGIONS-1:0] WAIT_STATES  = 16'h0000,
  parameter int                     BERR_TIMEOUT = 64,
  parameter int                     PHI_DIV      = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 phi1,
  output logic                 phi2,
  input  logic                 as_n,
  input  logic                 uds_n,
  input  logic                 lds_n,
  input  logic                 rw,
  input  logic [2:0]           fc,
  input  logic [23:1]          addr,
  input  logic [N_REGIONS-1:0] slave_ready,
  input  logic [6:0]           irq_in,
  output logic [N_REGIONS-1:0] sel,
  output logic                 dtack_n,
  output logic                 vpa_n,
  output logic                 berr_n,
  output logic [2:0]           ipl_n
);

  localparam int IW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
  localparam int PW = $clog2(PHI_DIV);
  localparam logic [PW-1:0] PMAX = PW'(PHI_DIV - 1);
  localparam logic [PW-1:0] PHALF = PW'(PHI_DIV / 2);
  localparam logic [7:0] TMO = 8'(BERR_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_ACK, S_BERR, S_IACK, S_END
  } state_t;

  state_t state, nstate;

  logic [PW-1:0] pcnt, pcnt_nxt;
  logic [3:0] wcnt;
  logic [7:0] tcnt;
  logic [IW-1:0] ridx, hit_idx, cur_idx;
  logic hit, iack, rdy;

  logic [N_REGIONS-1:0] sel_d;
  logic dtack_d, berr_d, vpa_d;

  logic unused;
  assign unused = ^{uds_n, lds_n, rw, addr[3:1]};

  assign pcnt_nxt = (pcnt == PMAX) ? '0 : pcnt + PW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pcnt <= '0;
      phi1 <= 1'b0;
      phi2 <= 1'b0;
    end else begin
      pcnt <= pcnt_nxt;
      phi1 <= (pcnt_nxt == '0);
      phi2 <= (pcnt_nxt == PHALF);
    end
  end

  // lowest index wins: scan downwards so the last hit is the lowest
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((addr[23:16] & REGION_MASK[8*i +: 8])
          == REGION_BASE[8*i +: 8]) begin
        hit = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign cur_idx = (state == S_IDLE) ? hit_idx : ridx;
  assign rdy = slave_ready[ridx];

`ifdef FX68_BUS_IRQ_EN
  logic [6:0] irq_s1, irq_s2;
  logic [2:0] lvl;

  assign iack = (fc == 3'b111) && (&addr[23:4]);

  always_comb begin
    lvl = '0;
    for (int k = 0; k < 7; k++)
      if (irq_s2[k]) lvl = 3'(k + 1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_s1 <= '0;
      irq_s2 <= '0;
      ipl_n <= 3'b111;
    end else begin
      irq_s1 <= irq_in;
      irq_s2 <= irq_s1;
      ipl_n <= ~lvl;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = ^{fc, irq_in, addr[15:4]};
  assign iack = 1'b0;
  assign ipl_n = 3'b111;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE:
        if (!as_n) begin
          if (iack) nstate = S_IACK;
          else if (hit) nstate = S_WAIT;
          else nstate = S_BERR;
        end
      S_WAIT:
        if (as_n) nstate = S_END;
        else if (wcnt == '0 && rdy) nstate = S_ACK;
        else if (tcnt == TMO) nstate = S_BERR;
      S_ACK, S_BERR, S_IACK:
        if (as_n) nstate = S_END;
      S_END: nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // strobes entered straight from IDLE are held back one edge (E1)
  always_comb begin
    sel_d = '0;
    dtack_d = 1'b1;
    berr_d = 1'b1;
    vpa_d = 1'b1;
    if (nstate == S_WAIT || nstate == S_ACK) sel_d[cur_idx] = 1'b1;
    if (nstate == S_ACK) dtack_d = 1'b0;
    if (nstate == S_BERR && state != S_IDLE) berr_d = 1'b0;
    if (nstate == S_IACK && state != S_IDLE) vpa_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel <= '0;
      dtack_n <= 1'b1;
      berr_n <= 1'b1;
      vpa_n <= 1'b1;
    end else begin
      sel <= sel_d;
      dtack_n <= dtack_d;
      berr_n <= berr_d;
      vpa_n <= vpa_d;
    end
  end

  // timeout count equals k at edge Ek
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wcnt <= '0;
      tcnt <= '0;
      ridx <= '0;
    end else if (state == S_IDLE && !as_n) begin
      ridx <= hit_idx;
      wcnt <= WAIT_STATES[{hit_idx, 2'b00} +: 4];
      tcnt <= 8'd1;
    end else if (state == S_WAIT) begin
      if (wcnt != '0) wcnt <= wcnt - 4'd1;
      if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fx68_bus_ctrl.sv
// tb_fx68_bus_ctrl: directed bench for fx68_bus_ctrl with a
// cycle-timeline model compared every clk plus literal spot checks.
module tb_fx68_bus_ctrl;

  localparam int NR = 4;
  localparam logic [31:0] BASE = 32'hE0C08000;
  localparam logic [31:0] MASK = 32'hE0E0E080;
  localparam logic [15:0] WS = 16'h0030;
  localparam int TMO = 64;
  localparam int PD = 2;

  localparam int K_REG = 0, K_UNMAP = 1, K_IACK = 2;
  localparam int R_NONE = 0, R_DTACK = 1, R_BERR = 2, R_VPA = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw = 1'b1;
  logic [2:0] fc = 3'b101;
  logic [23:1] addr = '0;
  logic [3:0] slave_ready = 4'hF;
  logic [6:0] irq_in = '0;
  logic phi1, phi2, dtack_n, vpa_n, berr_n;
  logic [3:0] sel;
  logic [2:0] ipl_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fx68_bus_ctrl #(
    .N_REGIONS(NR), .REGION_BASE(BASE), .REGION_MASK(MASK),
    .WAIT_STATES(WS), .BERR_TIMEOUT(TMO), .PHI_DIV(PD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .phi1(phi1), .phi2(phi2),
    .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
    .fc(fc), .addr(addr), .slave_ready(slave_ready),
    .irq_in(irq_in), .sel(sel), .dtack_n(dtack_n),
    .vpa_n(vpa_n), .berr_n(berr_n), .ipl_n(ipl_n)
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  function automatic int region_of(input logic [7:0] hi);
    for (int i = 0; i < NR; i++)
      if ((hi & MASK[8*i +: 8]) == BASE[8*i +: 8]) return i;
    return -1;
  endfunction

  function automatic logic [2:0] ipl_of(input logic [6:0] v);
    int lvl = 0;
    for (int k = 0; k < 7; k++) if (v[k]) lvl = k + 1;
    return ~3'(lvl);
  endfunction

  // timeline model: e = edges since E0, resp = sticky response
  int n_edges = 0, e = 0, r = 0, w = 0;
  int kind = K_REG, resp = R_NONE;
  bit busy = 0, gap = 0;
  logic [6:0] h0 = '0, h1 = '0, h2 = '0;
  logic [3:0] x_sel;
  logic [2:0] x_ipl;
  logic x_dt, x_be, x_vp, x_p1, x_p2;

  always @(posedge clk) begin
    if (!reset_n) begin
      n_edges = 0; busy = 0; gap = 0; resp = R_NONE;
      h0 = '0; h1 = '0; h2 = '0;
    end else begin
      n_edges++;
      h2 = h1; h1 = h0; h0 = irq_in;
      if (gap) gap = 0;
      else if (!busy) begin
        if (!as_n) begin
          busy = 1; e = 0; resp = R_NONE;
          r = region_of(addr[23:16]);
`ifdef FX68_BUS_IRQ_EN
          if (fc == 3'b111 && (&addr[23:4])) kind = K_IACK;
          else
`endif
          if (r < 0) kind = K_UNMAP;
          else begin kind = K_REG; w = int'(WS[4*r +: 4]); end
        end
      end else begin
        e++;
        if (as_n) begin
          busy = 0; gap = 1; resp = R_NONE;
        end else if (resp == R_NONE) begin
          if (kind == K_UNMAP) resp = R_BERR;
          else if (kind == K_IACK) resp = R_VPA;
          else if (e >= 1 + w && slave_ready[r]) resp = R_DTACK;
          else if (e >= TMO) resp = R_BERR;
        end
      end
    end
    x_sel = (busy && kind == K_REG && (resp == R_NONE || resp == R_DTACK))
            ? 4'(1 << r) : 4'b0;
    x_dt = !(resp == R_DTACK);
    x_be = !(resp == R_BERR);
    x_vp = !(resp == R_VPA);
    x_p1 = (n_edges > 0) && (n_edges % PD == 0);
    x_p2 = (n_edges % PD == PD / 2) && (n_edges > 0);
`ifdef FX68_BUS_IRQ_EN
    x_ipl = ipl_of(h2);
`else
    x_ipl = 3'b111;
`endif
    #1;
    chk("cyc", {sel, dtack_n, berr_n, vpa_n, phi1, phi2, ipl_n},
        {x_sel, x_dt, x_be, x_vp, x_p1, x_p2, x_ipl});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_start(input logic [23:0] a, input logic [2:0] f);
    @(negedge clk);
    addr = a[23:1]; fc = f; as_n = 1'b0;
    uds_n = 1'b0; lds_n = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_end();
    @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
  endtask

  logic [23:0] loop_addr [6] = '{24'h000100, 24'h900000, 24'hC01234,
                                 24'hB00000, 24'hFF0000, 24'h7FFFFE};

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset", {phi1, phi2, sel, dtack_n, berr_n, vpa_n, ipl_n},
        {2'b00, 4'b0000, 3'b111, 3'b111});
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();

    // zero-wait read of region 0
    bus_start(24'h000100, 3'b101);
    step(); chk("t1_sel_e0", sel, 4'b0001);
    chk("t1_dtack_e0", dtack_n, 1'b1);
    step(); chk("t1_dtack_e1", dtack_n, 1'b0);
    bus_end(); step();
    chk("t1_release", {sel, dtack_n}, {4'b0000, 1'b1});
    step();

    // three wait states in region 1
    bus_start(24'h800000, 3'b101);
    step(); chk("t2_sel_e0", sel, 4'b0010);
    repeat (3) step(); chk("t2_dtack_e3", dtack_n, 1'b1);
    step(); chk("t2_dtack_e4", dtack_n, 1'b0);
    bus_end(); step(); step();

    // unmapped
    bus_start(24'hA00000, 3'b101);
    step(); chk("t3_sel_e0", sel, 4'b0000);
    step(); chk("t3_berr_e1", {berr_n, dtack_n}, 2'b01);
    bus_end(); step(); step();

    // timeout with slave never ready
    @(negedge clk); slave_ready = 4'b1110;
    bus_start(24'h000100, 3'b101);
    step(); repeat (63) step();
    chk("t4_e63", {sel, berr_n}, {4'b0001, 1'b1});
    step(); chk("t4_e64", {sel, berr_n, dtack_n}, {4'b0000, 2'b01});
    repeat (30) step(); chk("t4_hold", berr_n, 1'b0);
    bus_end(); step(); chk("t4_release", berr_n, 1'b1);
    step();

    // as_n rises on the timeout edge: no bus error
    bus_start(24'h000100, 3'b101);
    step(); repeat (63) step();
    bus_end(); step();
    chk("t5_as_vs_tmo", {sel, berr_n, dtack_n}, {4'b0000, 2'b11});
    step();

    // ready on the timeout edge: ack wins
    bus_start(24'h000100, 3'b101);
    step(); repeat (63) step();
    @(negedge clk); slave_ready = 4'b1111;
    step(); chk("t6_rdy_vs_tmo", {berr_n, dtack_n}, 2'b10);
    bus_end(); step(); step();

    // late ready
    @(negedge clk); slave_ready = 4'b1110;
    bus_start(24'h000100, 3'b101);
    step(); repeat (4) step(); chk("t7_e4", dtack_n, 1'b1);
    @(negedge clk); slave_ready = 4'b1111;
    step(); chk("t7_e5", dtack_n, 1'b0);
    bus_end(); step(); step();

`ifdef FX68_BUS_IRQ_EN
    @(negedge clk); irq_in = 7'b0010100;
    step(); step(); chk("t8_ipl_2clk", ipl_n, 3'b111);
    step(); chk("t8_ipl_3clk", ipl_n, 3'b010);
    bus_start(24'hFFFFFA, 3'b111);
    uds_n = 1'b1;
    step(); chk("t8_iack_e0", {sel, vpa_n}, {4'b0000, 1'b1});
    step(); chk("t8_iack_e1", {vpa_n, dtack_n}, 2'b01);
    bus_end(); step(); chk("t8_iack_rel", vpa_n, 1'b1);
    step();
    @(negedge clk); irq_in = 7'b1000001;
    repeat (3) step(); chk("t8_nmi", ipl_n, 3'b000);
`else
    @(negedge clk); irq_in = 7'b0010100;
    repeat (3) step(); chk("t8_ipl_off", ipl_n, 3'b111);
    bus_start(24'hFFFFFA, 3'b111);
    step(); chk("t8_iack_r3", sel, 4'b1000);
    step(); chk("t8_iack_dtack", {vpa_n, dtack_n}, 2'b10);
    bus_end(); step(); step();
`endif

    // reset during wait states with dtack pending
    bus_start(24'h800000, 3'b101);
    step(); step();
    #1 reset_n = 1'b0;
    #1 chk("t9_async_rst",
           {phi1, phi2, sel, dtack_n, berr_n, vpa_n, ipl_n},
           {2'b00, 4'b0000, 3'b111, 3'b111});
    @(negedge clk); as_n = 1'b1;
    step();
    @(negedge clk); reset_n = 1'b1;
    bus_start(24'h000100, 3'b101);
    step(); chk("t9_post_sel", sel, 4'b0001);
    step(); chk("t9_post_dtack", dtack_n, 1'b0);
    bus_end(); step(); step();

    // back-to-back cycles across regions
    irq_in = 7'b0000010;
    for (int i = 0; i < 6; i++) begin
      bus_start(loop_addr[i], 3'b101);
      repeat (6) step();
      bus_end(); step();
    end
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fx68_bus_ctrl.md
# fx68_bus_ctrl

Parametrised 68000 bus controller that sits between the `fx68k` core and its memories and peripherals. It replaces hard-tied `DTACKn`/`VPAn`/`BERRn`/`IPLn` with a real bus-cycle state machine. It generates the phi1/phi2 clock enables and decodes the CPU address into N one-hot slave selects. It also inserts per-region wait states, honours slave ready, raises bus error on unmapped addresses or timeout, and answers interrupt-acknowledge cycles with autovectors.

## Interface
Parameters:
- `N_REGIONS`, 4: number of decoded slave regions.
- `REGION_BASE`, 32'hE0C08000: packed bases; region i compares against bits [8i+7:8i] (r0=0x00, r1=0x80, r2=0xC0, r3=0xE0).
- `REGION_MASK`, 32'hE0E0E080: packed masks, same packing. Region i matches when (addr[23:16] & mask_i) == base_i.
- `WAIT_STATES`, 16'h0000: packed 4-bit wait counts per region, in clk cycles.
- `BERR_TIMEOUT`, 64: clk cycles from cycle start to forced bus error; range 2..255.
- `PHI_DIV`, 2: clk cycles per CPU phase pair; even, ≥2.

Ports:
- `clk` in 1: CPU clock (clk_cpu domain).
- `reset_n` in 1: asynchronous, active-low reset.
- `phi1`, `phi2` out 1: one-clk-wide enables to fx68k `enPhi1`/`enPhi2`.
- `as_n`, `uds_n`, `lds_n`, `rw` in 1: CPU strobes, synchronous to clk.
- `fc` in 3: CPU function code.
- `addr` in 23: CPU address [23:1].
- `slave_ready` in N_REGIONS: per-region ready; 1 = data valid/accepted.
- `irq_in` in 7: level interrupt requests; bit k = level k+1.
- `sel` out N_REGIONS: one-hot slave select.
- `dtack_n`, `vpa_n`, `berr_n` out 1: to CPU.
- `ipl_n` out 3: encoded interrupt priority, active-low.

## Operation
- Reset values: `phi1`=0, `phi2`=0, `sel`=0, `dtack_n`=1, `vpa_n`=1, `berr_n`=1, `ipl_n`=3'b111, state IDLE, all counters 0.
- Phi generator:
  - Counter 0..PHI_DIV-1.
  - `phi1`=1 for the single clk where count==0.
  - `phi2`=1 where count==PHI_DIV/2.
  - With PHI_DIV=2 this gives strict alternation.
- States: IDLE, WAIT, ACK, BERR, IACK, END.
- IDLE: when `as_n` is sampled 0, latch the region; this edge is E0.
  - `fc`==3'b111 and addr[23:4] all ones → IACK. IACK has priority over decode.
  - Else the lowest-index matching region r → `sel`[r]=1, wait counter loads WAIT_STATES[r], → WAIT.
  - No match → BERR.
- WAIT:
  - Wait counter decrements each clk to 0.
  - When counter==0 and `slave_ready`[r]==1 → ACK with `dtack_n`=0.
  - Timeout counter runs from E0. Reaching BERR_TIMEOUT before ACK → BERR and `sel`=0.
- ACK / BERR / IACK:
  - Hold `dtack_n` / `berr_n` / `vpa_n` respectively at 0 until `as_n` is sampled 1.
  - Then → END: deassert all strokes and `sel`.
- END: one clk, → IDLE. Back-to-back cycles are accepted from the next edge.
- Interrupts:
  - `irq_in` passes through a two-flop synchroniser.
  - Highest set bit k gives level k+1, and `ipl_n` = ~level. None set → 3'b111.
  - Level 7 is passed like any other; the CPU treats it as NMI.
- Simultaneous events:
  - `as_n` rising on the same edge as timeout expiry → END, no `berr_n`.
  - `slave_ready` and timeout on the same edge → ACK wins.
- Reset mid-cycle: all outputs return to reset values immediately, without a clock edge.

## Timing
- Registered outputs only; no combinational path from CPU inputs to outputs.
- `sel` is valid after E0.
- `dtack_n` falls at E(1+W), where W = wait count, if `slave_ready` is already high; otherwise on the first edge after ready.
- Unmapped address: `berr_n` falls at E1.
- IACK: `vpa_n` falls at E1.
- Timeout: `berr_n` falls at E(BERR_TIMEOUT).
- Strobe release: within 1 clk of `as_n` sampled high.
- `ipl_n` latency: 3 clk from an `irq_in` change.

## Configuration
- `FX68_BUS_IRQ_EN`:
  - Defined: synchroniser, priority encoder and IACK autovector logic as above.
  - Undefined: `irq_in` ignored, `ipl_n` constant 3'b111. An IACK-pattern cycle is treated as an ordinary decode; with defaults it matches r3 and completes normally.

## Test plan
- Defaults, read 0x000100 → `sel`=4'b0001 after E0, `dtack_n`=0 at E1, release 1 clk after `as_n`=1.
- WAIT_STATES[7:4]=3, read 0x800000 → `sel`=4'b0010, `dtack_n`=0 at E4.
- Read 0xA00000 (unmapped) → `sel`=0, `berr_n`=0 at E1, `dtack_n` stays 1.
- Read 0x000100 with `slave_ready`[0]=0 for 100 clk → `berr_n`=0 at E64, `sel` cleared, no `dtack_n`.
- Macro defined: `irq_in`=7'b0010100 → `ipl_n`=3'b010 after 3 clk. Then `fc`=3'b111, addr 0xFFFFFA (byte) → `vpa_n`=0 at E1, `dtack_n`=1.
- Assert `reset_n`=0 during WAIT with `dtack_n` pending → all outputs at reset values before the next clk edge. After release, the first cycle decodes normally.
